dmem_arb_seq: RTL and testbench
===============================

Name: dmem_arb_seq

Overview:
- Data-memory access controller that shares one byte-wide, single-port data RAM between two requesters: port 0 is the CPU load/store unit and port 1 is the DMA/debug loader.
- Grants requesters round-robin and sequences each byte/half/word access as 1/2/4 byte beats.
- Assembles and sign- or zero-extends load data, and flags misaligned or illegal-size requests.
- Sits between the core's memory stage and the byte RAM.

Parameters:
- XLEN, 32, data and address width of requester ports.
- AW, 12, byte-address width of the RAM (4096 bytes).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- rN_req  in  1  request, N=0,1; held with its fields until rN_gnt
- rN_we  in  1  1 = store, 0 = load
- rN_size  in  2  01 byte, 10 half, 11 word, 00 illegal
- rN_lu  in  1  load unsigned (zero-extend)
- rN_addr  in  XLEN  byte address
- rN_wdata  in  XLEN  store data, low bytes used
- rN_gnt  out  1  one-cycle accept pulse; request fields sampled this cycle
- rN_done  out  1  one-cycle completion pulse
- rN_err  out  1  valid with rN_done: misaligned or illegal size
- rN_rdata  out  XLEN  load result, valid with rN_done, held until next done on that port
- m_en  out  1  RAM beat enable
- m_we  out  1  RAM byte write
- m_addr  out  AW  RAM byte address
- m_wdata  out  8  RAM write byte
- m_rdata  in  8  RAM read byte, returned the cycle after m_en with m_we=0

Behaviour:
Reset:
- Reset is synchronous, active-low on rstn, sampled at clk rising edge.
- state=IDLE, last_grant=1 (port 0 wins the first tie).
- All outputs 0: gnt, done, err, rdata, m_en, m_we, m_addr, m_wdata.

FSM IDLE, ACCESS, DRAIN:
- IDLE: rN_gnt is driven combinationally from rN_req.
  - One requester asserting: it is granted.
  - Both asserting: grant the port other than last_grant.
  - On grant: latch we, size, lu, addr, wdata and port id; update last_grant; beat count cnt=0; n = 1/2/4 beats from size.
  - Legal request: go to ACCESS. Illegal or misaligned request: go to DRAIN.
- ACCESS: m_en=1, m_we=we, m_addr=addr[AW-1:0]+cnt (mod 2^AW), m_wdata=wdata byte cnt.
  - Load: capture m_rdata into byte cnt-1 when cnt>0.
  - cnt==n-1: go to DRAIN. Otherwise cnt++.
- DRAIN: m_en=0.
  - Load: capture the final byte (n-1).
  - Drive rN_done=1 for the latched port only. rN_rdata is the assembled result; err as latched.
  - Next state IDLE. No grants are given in ACCESS or DRAIN.

Latency (grant in cycle T):
- done at T+n+1: byte T+2, half T+3, word T+5.
- Back-to-back throughput: one transaction per n+2 cycles.

Load extension (lu=0 sign-extends from bit 7 or 15; lu=1 zero-extends):
- Byte: {24{b0[7]},b0} or {24'b0,b0}.
- Half: {16{b1[7]},b1,b0} or {16'b0,b1,b0}.
- Word: {b3,b2,b1,b0}, little-endian; lu is ignored.

Stores and errors:
- Store: write byte k = wdata[8k+7:8k]. rdata is unchanged on store done.
- Error when size==00, or half with addr[0]=1, or word with addr[1:0]!=0.
  - No RAM beat is issued. done at T+1 with err=1, rdata=0.

Boundary conditions:
- addr bits above AW-1 are ignored.
- Address wrap: a word at 0xFFC stays within 0xFFC..0xFFF.
- Request deasserted before grant: no effect.
- req held after done: re-arbitrated in the next IDLE cycle.
- Reset mid-transaction: next cycle IDLE, no done. Bytes already written remain written.
- The other port's done, err and rdata never change during a transaction.

Test Plan:
- Reset, then r0 store word 0xDEADBEEF @0x010 -> r0_gnt at T, m_we beats at 0x010..0x013 with bytes EF,BE,AD,DE, r0_done at T+5, r0_err=0.
- r0 load byte @0x013, lu=0 -> r0_rdata=0xFFFFFFDE at T+2. Same load with lu=1 -> 0x000000DE. Load half @0x012, lu=0 -> 0xFFFFDEAD.
- r0 and r1 both request continuously (word loads) -> grants alternate 0,1,0,1 starting with port 0; each done only on its own port; grants spaced 6 cycles apart.
- r1 load word @0x002 -> no m_en, r1_done and r1_err at T+1, rdata=0. Half @0x001 and size=00 give the same response.
- r1 store half 0x1234 @0xFFE, then load word @0xFFC -> bytes 0xFFE=34, 0xFFF=12. r1_rdata[31:16]=0x1234 and the upper address bits of 0x1000FFC are ignored.
- rstn=0 at cycle T+2 of a word store @0x020 -> state IDLE, no done. Bytes 0x020 and 0x021 written; 0x022 and 0x023 keep their old values.

Source files
------------

// File: rtl/dmem_arb_seq.sv
// Shares one byte-wide single-port data RAM between two requesters with
// round-robin arbitration. Accesses run as 1/2/4 byte beats and loads are extended.
//
// state  | meaning
// IDLE   | arbitrate and latch the granted request
// ACCESS | one RAM beat per cycle, cnt = beat index
// DRAIN  | final read byte returns; done pulse to the owning port
module dmem_arb_seq #(
    parameter int XLEN = 32,
    parameter int AW   = 12
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            r0_req,
    input  logic            r0_we,
    input  logic [1:0]      r0_size,
    input  logic            r0_lu,
    input  logic [XLEN-1:0] r0_addr,
    input  logic [XLEN-1:0] r0_wdata,
    output logic            r0_gnt,
    output logic            r0_done,
    output logic            r0_err,
    output logic [XLEN-1:0] r0_rdata,
    input  logic            r1_req,
    input  logic            r1_we,
    input  logic [1:0]      r1_size,
    input  logic            r1_lu,
    input  logic [XLEN-1:0] r1_addr,
    input  logic [XLEN-1:0] r1_wdata,
    output logic            r1_gnt,
    output logic            r1_done,
    output logic            r1_err,
    output logic [XLEN-1:0] r1_rdata,
    output logic            m_en,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [7:0]      m_wdata,
    input  logic [7:0]      m_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

    state_t          state;
    logic            last_grant, port_q, we_q, lu_q, err_q;
    logic [1:0]      size_q, cnt, nm1, cnt_m1;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q, rbuf, full;
    logic [XLEN-1:0] rdata0_q, rdata1_q, ld_res, new_rdata;
    logic            g0, g1, sgn;
    logic            s_we, s_lu, s_bad;
    logic [1:0]      s_size;
    logic [XLEN-1:0] s_addr, s_wdata;
    logic            unused_hi;

    // the port that was not granted last wins a tie
    assign g0 = rstn && (state == IDLE) && r0_req && (!r1_req || last_grant);
    assign g1 = rstn && (state == IDLE) && r1_req && (!r0_req || !last_grant);

    assign s_we    = g1 ? r1_we    : r0_we;
    assign s_lu    = g1 ? r1_lu    : r0_lu;
    assign s_size  = g1 ? r1_size  : r0_size;
    assign s_addr  = g1 ? r1_addr  : r0_addr;
    assign s_wdata = g1 ? r1_wdata : r0_wdata;
    assign s_bad   = (s_size == 2'b00) ||
                     (s_size == 2'b10 && s_addr[0]) ||
                     (s_size == 2'b11 && s_addr[1:0] != 2'b00);
    assign unused_hi = ^{s_addr, s_wdata};

    assign cnt_m1 = cnt - 2'd1;

    // last byte comes straight from the RAM during DRAIN
    always_comb begin
        full = rbuf;
        full[{nm1, 3'b000} +: 8] = m_rdata;
        sgn = 1'b0;
        if (!lu_q)
            sgn = (size_q == 2'b01) ? full[7] : (size_q == 2'b10) ? full[15] : 1'b0;
        ld_res = {XLEN{sgn}};
        case (size_q)
            2'b01:   ld_res[7:0]  = full[7:0];
            2'b10:   ld_res[15:0] = full[15:0];
            default: ld_res[31:0] = full;
        endcase
        new_rdata = err_q ? '0 : ld_res;
    end

    assign r0_gnt   = g0;
    assign r1_gnt   = g1;
    assign r0_done  = (state == DRAIN) && !port_q;
    assign r1_done  = (state == DRAIN) && port_q;
    assign r0_err   = r0_done && err_q;
    assign r1_err   = r1_done && err_q;
    assign r0_rdata = (r0_done && (err_q || !we_q)) ? new_rdata : rdata0_q;
    assign r1_rdata = (r1_done && (err_q || !we_q)) ? new_rdata : rdata1_q;

    assign m_en    = (state == ACCESS);
    assign m_we    = m_en && we_q;
    assign m_addr  = m_en ? addr_q + AW'(cnt) : '0;
    assign m_wdata = m_we ? wdata_q[{cnt, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            lu_q       <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            cnt        <= 2'd0;
            nm1        <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (g0 || g1) begin
                        port_q     <= g1;
                        last_grant <= g1;
                        we_q       <= s_we;
                        lu_q       <= s_lu;
                        size_q     <= s_size;
                        err_q      <= s_bad;
                        addr_q     <= s_addr[AW-1:0];
                        wdata_q    <= s_wdata[31:0];
                        rbuf       <= '0;
                        cnt        <= 2'd0;
                        nm1        <= (s_size == 2'b11) ? 2'd3 : (s_size == 2'b10) ? 2'd1 : 2'd0;
                        state      <= s_bad ? DRAIN : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q && cnt != 2'd0)
                        rbuf[{cnt_m1, 3'b000} +: 8] <= m_rdata;
                    if (cnt == nm1)
                        state <= DRAIN;
                    else
                        cnt <= cnt + 2'd1;
                end
                DRAIN: begin
                    if (!port_q)
                        rdata0_q <= r0_rdata;
                    else
                        rdata1_q <= r1_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arb_seq.sv
// Bench for dmem_arb_seq: byte RAM model plus a transaction-level reference
// memory; directed cases followed by randomized single-port traffic.
module tb_dmem_arb_seq;
    localparam int XLEN = 32;
    localparam int AW   = 12;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            r0_req = 0, r0_we = 0, r0_lu = 0;
    logic [1:0]      r0_size = 0;
    logic [XLEN-1:0] r0_addr = 0, r0_wdata = 0;
    logic            r0_gnt, r0_done, r0_err;
    logic [XLEN-1:0] r0_rdata;
    logic            r1_req = 0, r1_we = 0, r1_lu = 0;
    logic [1:0]      r1_size = 0;
    logic [XLEN-1:0] r1_addr = 0, r1_wdata = 0;
    logic            r1_gnt, r1_done, r1_err;
    logic [XLEN-1:0] r1_rdata;
    logic            m_en, m_we;
    logic [AW-1:0]   m_addr;
    logic [7:0]      m_wdata;
    logic [7:0]      m_rdata = 8'h00;

    logic [7:0]  ram [4096];
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_rd [2];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arb_seq #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_lu(r0_lu),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
        .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_lu(r1_lu),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
        .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata <= ram[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic req, input logic we, input logic [1:0] sz,
                            input logic lu, input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            r0_req = req; r0_we = we; r0_size = sz; r0_lu = lu; r0_addr = a; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_size = sz; r1_lu = lu; r1_addr = a; r1_wdata = wd;
        end
    endtask

    function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b00) || (sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
    endfunction

    function automatic int nbeats(input logic [1:0] sz);
        return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic lu, input logic [31:0] a);
        logic [11:0] b;
        logic [7:0]  x0, x1, x2, x3;
        b  = a[11:0];
        x0 = ref_mem[b];
        x1 = ref_mem[b + 12'd1];
        x2 = ref_mem[b + 12'd2];
        x3 = ref_mem[b + 12'd3];
        case (sz)
            2'b01:   return lu ? {24'h0, x0} : {{24{x0[7]}}, x0};
            2'b10:   return lu ? {16'h0, x1, x0} : {{16{x1[7]}}, x1, x0};
            default: return {x3, x2, x1, x0};
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        set_port(0, 0, 0, 2'b00, 0, 0, 0);
        set_port(1, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, m_en, m_we}, 0);
        chk("rst_mbus", {m_addr, m_wdata}, 0);
        chk("rst_rdata0", r0_rdata, 0);
        chk("rst_rdata1", r1_rdata, 0);
        rstn = 1'b1;
        last_rd[0] = 0;
        last_rd[1] = 0;
    endtask

    task automatic txn(input int p, input logic we, input logic [1:0] sz, input logic lu,
                       input logic [31:0] a, input logic [31:0] wd);
        logic        bad, got_g, other_ok, done_p, err_p;
        int          n, dl;
        logic [31:0] exp_rd, rd_p, rz;
        logic [11:0] ba, ea;
        bad    = is_bad(sz, a);
        n      = nbeats(sz);
        dl     = bad ? 1 : n + 1;
        ba     = a[11:0];
        exp_rd = bad ? 32'h0 : (we ? last_rd[p] : ref_load(sz, lu, a));
        @(negedge clk);
        set_port(p, 1, we, sz, lu, a, wd);
        got_g = 0;
        for (int w = 0; w < 8; w++) begin
            #1;
            if ((p == 0) ? r0_gnt : r1_gnt) begin
                got_g = 1;
                break;
            end
            @(negedge clk);
        end
        chk("gnt", 32'(got_g), 1);
        if (!got_g) begin
            set_port(p, 0, 0, 2'b00, 0, 0, 0);
            return;
        end
        other_ok = 1;
        for (int i = 1; i <= dl; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rz = $urandom;
                set_port(p, 0, rz[0], rz[2:1], rz[3], $urandom, $urandom);
            end
            #1;
            done_p = (p == 0) ? r0_done : r1_done;
            err_p  = (p == 0) ? r0_err : r1_err;
            rd_p   = (p == 0) ? r0_rdata : r1_rdata;
            if ((p == 0) ? (r1_done || r1_rdata !== last_rd[1]) : (r0_done || r0_rdata !== last_rd[0]))
                other_ok = 0;
            if (i < dl) begin
                ea = ba + 12'(i - 1);
                chk("done_early", 32'(done_p), 0);
                chk("m_en", 32'(m_en), 1);
                chk("m_addr", 32'(m_addr), 32'(ea));
                chk("m_we", 32'(m_we), 32'(we));
                if (we) chk("m_wdata", 32'(m_wdata), 32'(wd[8*(i-1) +: 8]));
            end else begin
                chk("done", 32'(done_p), 1);
                chk("err", 32'(err_p), 32'(bad));
                chk("rdata", rd_p, exp_rd);
                chk("m_en_drain", 32'(m_en), 0);
            end
        end
        chk("other_port", 32'(other_ok), 1);
        if (we && !bad)
            for (int k = 0; k < n; k++) ref_mem[ba + 12'(k)] = wd[8*k +: 8];
        last_rd[p] = exp_rd;
    endtask

    task automatic arb_test();
        logic [31:0] e0, e1;
        logic [3:0]  exp_v, got_v;
        int slot, ph;
        e0 = ref_load(2'b11, 0, 32'h010);
        e1 = ref_load(2'b11, 0, 32'h100);
        @(negedge clk);
        set_port(0, 1, 0, 2'b11, 0, 32'h010, 0);
        set_port(1, 1, 0, 2'b11, 0, 32'h100, 0);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            slot  = k / 6;
            ph    = k % 6;
            exp_v = {ph == 0 && slot % 2 == 0, ph == 0 && slot % 2 == 1,
                     ph == 5 && slot % 2 == 0, ph == 5 && slot % 2 == 1};
            got_v = {r0_gnt, r1_gnt, r0_done, r1_done};
            chk("arb", 32'(got_v), 32'(exp_v));
            if (ph == 5)
                chk("arb_rdata", (slot % 2 == 0) ? r0_rdata : r1_rdata, (slot % 2 == 0) ? e0 : e1);
        end
        @(negedge clk);
        set_port(0, 0, 0, 2'b00, 0, 0, 0);
        set_port(1, 0, 0, 2'b00, 0, 0, 0);
        last_rd[0] = e0;
        last_rd[1] = e1;
    endtask

    task automatic reset_mid_test();
        txn(0, 1, 2'b11, 0, 32'h020, 32'h11223344);
        @(negedge clk);
        set_port(0, 1, 1, 2'b11, 0, 32'h020, 32'hAABBCCDD);
        #1 chk("rst_mid_gnt", 32'(r0_gnt), 1);
        @(negedge clk);
        set_port(0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rstn = 1'b1;
            #1 chk("rst_mid_quiet", 32'({r0_done, r1_done, m_en}), 0);
        end
        ref_mem[12'h020] = 8'hDD;
        ref_mem[12'h021] = 8'hCC;
        last_rd[0] = 0;
        last_rd[1] = 0;
        txn(0, 0, 2'b11, 0, 32'h020, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r, mism;
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_rd[0] = 0;
        last_rd[1] = 0;

        do_reset();
        txn(0, 1, 2'b11, 0, 32'h010, 32'hDEADBEEF);
        txn(0, 0, 2'b01, 0, 32'h013, 0);
        txn(0, 0, 2'b01, 1, 32'h013, 0);
        txn(0, 0, 2'b10, 0, 32'h012, 0);

        do_reset();
        arb_test();

        txn(1, 0, 2'b11, 0, 32'h002, 0);
        txn(1, 0, 2'b10, 0, 32'h001, 0);
        txn(1, 0, 2'b00, 0, 32'h004, 0);
        txn(1, 1, 2'b10, 0, 32'h00000FFE, 32'h00001234);
        txn(1, 0, 2'b11, 0, 32'h01000FFC, 0);

        reset_mid_test();

        for (int t = 0; t < 200; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r == 0) ? 2'b00 : 2'(r % 3 + 1);
            a  = $urandom;
            a[11:0] = {($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00, 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 3) != 0)
                a = a & ~((sz == 2'b11) ? 32'h3 : (sz == 2'b10) ? 32'h1 : 32'h0);
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        mism = 0;
        for (int i = 0; i < 4096; i++)
            if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_image", mism, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
